// File: rtl/csense_adc_seq.sv
// csense_adc_seq: round-robin SPI scanner for an LTC2418-class current-sense ADC; optional macro CSENSE_ADC_ECHO_CHK_EN
module csense_adc_seq #(
  parameter int CLK_DIV     = 25,
  parameter int EOC_TIMEOUT = 5000000,
  parameter int CS_HIGH_MIN = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        fo_i,
  input  logic [15:0] ch_mask_i,
  output logic        adc_cs_n_o,
  output logic        adc_sck_o,
  output logic        adc_sdi_o,
  input  logic        adc_sdo_i,
  output logic        adc_fo_o,
  output logic        res_valid_o,
  output logic [3:0]  res_ch_o,
  output logic [23:0] res_data_o,
  output logic        res_sig_o,
  output logic        res_err_o,
  output logic        timeout_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, SELECT, SHIFT, CHECK, RELEASE} state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, tx_q, tx_d;
  logic [30:0] rx_q, rx_d;
  logic [4:0]  bit_q, bit_d;
  logic [3:0]  ch_q, ch_d, tag_q, tag_d, rch_q, rch_d;
  logic [23:0] data_q, data_d;
  logic sck_q, sck_d, fo_q, fo_d, first_q, first_d, stop_q, stop_d, to_q, to_d;
  logic vld_q, vld_d, sig_q, sig_d, err_q, err_d, go_rel, err_w;
  function automatic logic [3:0] next_ch(input logic [15:0] m, input logic [3:0] c);
    logic [3:0] r, k;
    logic hit;
    r = c;
    hit = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      k = c + 4'(i);
      if (!hit && m[k]) begin
        r = k;
        hit = 1'b1;
      end
    end
    return r;
  endfunction
`ifdef CSENSE_ADC_ECHO_CHK_EN
  assign err_w = rx_q[30] | (rx_q[4:0] != {1'b1, tag_q});
`else
  logic unused_echo;
  assign unused_echo = ^rx_q[4:0];
  assign err_w = rx_q[30];
`endif
  assign adc_cs_n_o  = !(state_q inside {SELECT, SHIFT, CHECK});
  assign adc_sck_o   = sck_q;
  assign adc_sdi_o   = tx_q[31];
  assign adc_fo_o    = fo_q;
  assign res_valid_o = vld_q;
  assign res_ch_o    = rch_q;
  assign res_data_o  = data_q;
  assign res_sig_o   = sig_q;
  assign res_err_o   = err_q;
  assign timeout_o   = to_q;
  assign busy_o      = state_q != IDLE;
  // next-state: frame sequencing, SCK generation, result capture; fo/mask sampled on RELEASE entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    tag_d   = tag_q;
    sck_d   = sck_q;
    fo_d    = fo_q;
    first_d = first_q;
    stop_d  = stop_q;
    to_d    = to_q & enable_i;
    vld_d   = 1'b0;
    rch_d   = rch_q;
    data_d  = data_q;
    sig_d   = sig_q;
    err_d   = err_q;
    go_rel  = 1'b0;
    case (state_q)
      IDLE: begin
        fo_d  = fo_i;
        cnt_d = '0;
        if (enable_i && |ch_mask_i) begin
          state_d = SELECT;
          ch_d    = next_ch(ch_mask_i, 4'hF);
          first_d = 1'b1;
        end
      end
      SELECT: begin
        if (!adc_sdo_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = {4'b1011, ch_q, 24'h0};
        end else if (cnt_q == 32'(EOC_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          first_d = 1'b1;
          go_rel  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == 32'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = !sck_q;
          rx_d  = sck_q ? rx_q : {rx_q[29:0], adc_sdo_i};
          tx_d  = sck_q ? tx_q << 1 : tx_q;
          bit_d = sck_q ? bit_q + 5'd1 : bit_q;
          state_d = (sck_q && bit_q == 5'd31) ? CHECK : SHIFT;
        end
      end
      CHECK: begin
        vld_d   = !first_q;
        first_d = 1'b0;
        tag_d   = ch_q;
        rch_d   = first_q ? rch_q : tag_q;
        data_d  = first_q ? data_q : rx_q[28:5];
        sig_d   = first_q ? sig_q : rx_q[29];
        err_d   = first_q ? err_q : err_w;
        go_rel  = 1'b1;
      end
      RELEASE: begin
        if (cnt_q == 32'(CS_HIGH_MIN - 1)) begin
          cnt_d   = '0;
          state_d = (!enable_i || stop_q) ? IDLE : SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_rel) begin
      state_d = RELEASE;
      cnt_d   = '0;
      fo_d    = fo_i;
      ch_d    = next_ch(ch_mask_i, ch_q);
      stop_d  = ~|ch_mask_i;
    end
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      tag_q   <= '0;
      sck_q   <= 1'b0;
      fo_q    <= 1'b0;
      first_q <= 1'b0;
      stop_q  <= 1'b0;
      to_q    <= 1'b0;
      vld_q   <= 1'b0;
      rch_q   <= '0;
      data_q  <= '0;
      sig_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      tag_q   <= tag_d;
      sck_q   <= sck_d;
      fo_q    <= fo_d;
      first_q <= first_d;
      stop_q  <= stop_d;
      to_q    <= to_d;
      vld_q   <= vld_d;
      rch_q   <= rch_d;
      data_q  <= data_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_csense_adc_seq.sv
// tb_csense_adc_seq: directed bench with an ADC bus model for csense_adc_seq
module tb_csense_adc_seq;
  localparam int CLK_DIV = 2, EOC_TO = 300, CS_MIN = 6;
`ifdef CSENSE_ADC_ECHO_CHK_EN
  localparam logic ECHO_ERR = 1'b1;
`else
  localparam logic ECHO_ERR = 1'b0;
`endif
  logic clk = 0, reset = 1, enable = 0, fo_i = 0, sdo = 1;
  logic [15:0] ch_mask = '0;
  logic cs_n, sck, sdi, fo_o, res_valid, res_sig, res_err, timeout, busy;
  logic [3:0] res_ch;
  logic [23:0] res_data;
  int n_chk = 0, n_err = 0;
  csense_adc_seq #(.CLK_DIV(CLK_DIV), .EOC_TIMEOUT(EOC_TO), .CS_HIGH_MIN(CS_MIN)) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .fo_i(fo_i), .ch_mask_i(ch_mask),
    .adc_cs_n_o(cs_n), .adc_sck_o(sck), .adc_sdi_o(sdi), .adc_sdo_i(sdo), .adc_fo_o(fo_o),
    .res_valid_o(res_valid), .res_ch_o(res_ch), .res_data_o(res_data), .res_sig_o(res_sig),
    .res_err_o(res_err), .timeout_o(timeout), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // ADC model: EOC after eoc_dly cycles of CS low, frame MSB first, SDI captured on SCK rise
  logic [31:0] frame = 32'h3ABC_DE20;
  int eoc_dly = 100, bcnt = 0, bidx = 31, nbit = 0;
  logic psck = 0;
  logic [7:0] cmd;
  logic [7:0] cmds[$];
  always @(negedge clk) begin
    if (cs_n) begin
      bcnt = 0; bidx = 31; nbit = 0; sdo = 1'b1;
    end else begin
      bcnt++;
      if (sck && !psck) begin
        nbit++;
        if (nbit <= 8) cmd = {cmd[6:0], sdi};
        if (nbit == 8) cmds.push_back(cmd);
      end
      if (!sck && psck && bidx > 0) bidx--;
      sdo = (bcnt > eoc_dly || nbit > 0) ? frame[bidx] : 1'b1;
    end
    psck = sck;
  end
  logic [3:0] rch[$];
  logic [23:0] rdat[$];
  logic rsig[$], rerr[$];
  int rcmd[$];
  int nres = 0;
  always @(negedge clk) if (res_valid) begin
    rch.push_back(res_ch); rdat.push_back(res_data); rsig.push_back(res_sig);
    rerr.push_back(res_err); rcmd.push_back(cmds.size()); nres++;
  end
  task automatic wait_res(input int target);
    int n = 0;
    while (nres < target && n < 3000) begin @(posedge clk); n++; end
    chk("wait_res", nres >= target, 1);
  endtask
  task automatic wait_cs(input logic v);
    int n = 0;
    while (cs_n !== v && n < 3000) begin @(negedge clk); n++; end
    chk("wait_cs", cs_n, v);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    chk("wait_idle", busy, 0);
  endtask
  initial begin
    int b, n;
    logic bad;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1); chk("rst_sck", sck, 0); chk("rst_sdi", sdi, 0);
    chk("rst_fo", fo_o, 0); chk("rst_valid", res_valid, 0); chk("rst_ch", res_ch, 0);
    chk("rst_data", res_data, 0); chk("rst_timeout", timeout, 0); chk("rst_busy", busy, 0);
    fo_i = 1; repeat (2) @(negedge clk); chk("fo_idle1", fo_o, 1);
    fo_i = 0; repeat (2) @(negedge clk); chk("fo_idle0", fo_o, 0);
    frame = 32'h3ABC_DE20; eoc_dly = 100; ch_mask = 16'h0005; enable = 1;
    wait_cs(0);
    bad = 0;
    repeat (40) begin
      @(posedge clk); fo_i = ~fo_i;
      @(negedge clk); if (!cs_n && fo_o !== 1'b0) bad = 1;
    end
    fo_i = 1;
    chk("fo_stable", bad, 0);
    wait_cs(1);
    chk("fo_release", fo_o, 1);
    wait_res(3);
    chk("first_suppr", rcmd[0], 2);
    chk("cmd0", cmds[0], 8'hB0); chk("cmd1", cmds[1], 8'hB2); chk("cmd2", cmds[2], 8'hB0);
    chk("res0_ch", rch[0], 0); chk("res1_ch", rch[1], 2); chk("res2_ch", rch[2], 0);
    chk("res0_data", rdat[0], 24'hD5E6F1); chk("res0_sig", rsig[0], 1); chk("res0_err", rerr[0], 0);
    n = 0;
    while (!(nbit >= 4 && !cs_n) && n < 3000) begin @(negedge clk); n++; end
    b = nres; enable = 0;
    wait_idle();
    chk("disable_completes", nres, b + 1); chk("disable_cs_n", cs_n, 1);
    b = nres; frame = 32'h5ABC_DE20; ch_mask = 16'h0004; enable = 1;
    wait_res(b + 1);
    frame = 32'h3ABC_DE33;
    chk("dmy_ch", rch[b], 2); chk("dmy_err", rerr[b], 1); chk("dmy_sig", rsig[b], 0);
    wait_res(b + 2);
    frame = 32'h3ABC_DE32;
    chk("echo_bad_err", rerr[b + 1], ECHO_ERR); chk("echo_bad_ch", rch[b + 1], 2);
    wait_res(b + 3);
    chk("echo_ok_err", rerr[b + 2], 0); chk("echo_ok_sig", rsig[b + 2], 1);
    chk("single_cmd", cmds[cmds.size() - 1], 8'hB2);
    enable = 0;
    wait_idle();
    b = nres; eoc_dly = 1000000; ch_mask = 16'h0001; enable = 1;
    wait_cs(0);
    n = 0;
    while (timeout !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("timeout_set", timeout, 1); chk("timeout_cycles", n, EOC_TO);
    chk("timeout_cs_n", cs_n, 1); chk("timeout_novalid", nres, b);
    enable = 0;
    repeat (2) @(negedge clk);
    chk("timeout_clear", timeout, 0);
    wait_idle();
    eoc_dly = 100; frame = 32'h3ABC_DE20; ch_mask = 16'h0003; enable = 1;
    n = 0;
    while (!(nbit == 15 && !cs_n) && n < 3000) begin @(negedge clk); n++; end
    chk("reached_bit15", nbit, 15);
    b = nres; reset = 1;
    @(negedge clk);
    chk("mid_rst_cs_n", cs_n, 1); chk("mid_rst_sck", sck, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0); chk("mid_rst_sdi", sdi, 0);
    enable = 0;
    repeat (5) @(negedge clk);
    chk("mid_rst_nores", nres, b);
    reset = 0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
